// File: rtl/snn_sched_pkg.sv
// Shared types and helpers for the SNN injection scheduler.
package snn_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_FLT,
    RUN,
    WAIT_DONE,
    ADVANCE,
    FINISH
  } state_t;

  // Timestep bit copied into bit 0 of every injected ifmap packet.
  localparam int unsigned TS_BIT = 0;

  // Injection packet width for a given filter weight width.
  function automatic int unsigned pkt_width(input int unsigned filter_width);
    return 3 * filter_width + 9;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-request round-robin arbiter. Slot 0 is favoured after reset/clear.
// The pointer only moves when both requests contend and the grant is taken.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic [1:0] req,
  input  logic       adv,
  output logic [1:0] gnt
);

  // 1: slot 1 has priority on the next contended grant
  logic ptr;

  // Grant the requester favoured by the pointer, or the only requester.
  always_comb begin
    gnt    = '0;
    gnt[0] = req[0] && (!req[1] || !ptr);
    gnt[1] = req[1] && (!req[0] || ptr);
  end

  // Remember the last contended winner so the other side goes next.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= 1'b0;
    end else if (clr) begin
      ptr <= 1'b0;
    end else if (adv && (&req)) begin
      ptr <= gnt[0];
    end
  end

endmodule

// File: rtl/snn_inject_scheduler.sv
// Sequences all packet injection into the SNN PE mesh for one inference:
// filters once, then per timestep ifmap rows plus previous-timestep residue,
// then waits for every output PE to report done before advancing.
module snn_inject_scheduler
  import snn_sched_pkg::*;
#(
  parameter int unsigned FILTER_WIDTH = 8,
  parameter int unsigned PKT_WIDTH    = pkt_width(FILTER_WIDTH),
  parameter int unsigned NUM_PE       = 4,
  parameter int unsigned NUM_TS       = 2,
  parameter int unsigned FILTER_PKTS  = 3,
  parameter int unsigned IFMAP_PKTS   = 5,
  parameter int unsigned TS_W         = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 flt_valid,
  output logic                 flt_ready,
  input  logic [PKT_WIDTH-1:0] flt_data,
  input  logic                 ifm_valid,
  output logic                 ifm_ready,
  input  logic [PKT_WIDTH-1:0] ifm_data,
  input  logic                 res_valid,
  output logic                 res_ready,
  input  logic [PKT_WIDTH-1:0] res_data,
  output logic                 inj_valid,
  input  logic                 inj_ready,
  output logic [PKT_WIDTH-1:0] inj_data,
  input  logic [NUM_PE-1:0]    pe_done,
  output logic [TS_W-1:0]      timestep,
  output logic                 busy,
  output logic                 done
);

  localparam int unsigned FW = $clog2(FILTER_PKTS + 1);
  localparam int unsigned IW = $clog2(IFMAP_PKTS + 1);
  localparam int unsigned RW = $clog2(NUM_PE + 1);

  localparam logic [FW-1:0]   FLT_LAST = FW'(FILTER_PKTS - 1);
  localparam logic [IW-1:0]   IFM_MAX  = IW'(IFMAP_PKTS);
  localparam logic [RW-1:0]   RES_MAX  = RW'(NUM_PE);
  localparam logic [TS_W-1:0] TS_LAST  = TS_W'(NUM_TS - 1);

  state_t               state;
  logic [FW-1:0]        flt_cnt;
  logic [IW-1:0]        ifm_cnt;
  logic [RW-1:0]        res_cnt;
  logic [NUM_PE-1:0]    sticky;

  logic                 space;
  logic                 ifm_elig;
  logic                 res_elig;
  logic                 res_met;
  logic                 start_acc;
  logic                 flt_fire;
  logic                 ifm_fire;
  logic                 res_fire;
  logic                 arb_adv;
  logic [1:0]           req;
  logic [1:0]           gnt;
  logic [PKT_WIDTH-1:0] ifm_stamped;

  // Eligibility and arbitration requests; only RUN may request.
  always_comb begin
    space     = !inj_valid || inj_ready;
    start_acc = (state == IDLE) && start;
    ifm_elig  = ifm_cnt < IFM_MAX;
    res_elig  = (timestep != '0) && (res_cnt < RES_MAX);
    res_met   = (timestep == '0) ? (res_cnt == '0) : (res_cnt == RES_MAX);
    req       = '0;
    req[0]    = (state == RUN) && ifm_valid && ifm_elig;
    req[1]    = (state == RUN) && res_valid && res_elig;
  end

  rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (start_acc),
    .req   (req),
    .adv   (arb_adv),
    .gnt   (gnt)
  );

  // Source readies and accept strobes; the output slot must be free or draining.
  always_comb begin
    flt_ready   = (state == LOAD_FLT) && space;
    ifm_ready   = gnt[0] && space;
    res_ready   = gnt[1] && space;
    flt_fire    = flt_valid && flt_ready;
    ifm_fire    = ifm_valid && ifm_ready;
    res_fire    = res_valid && res_ready;
    arb_adv     = ifm_fire || res_fire;
    ifm_stamped = ifm_data;
    ifm_stamped[0] = timestep[TS_BIT];
  end

  // Control FSM with the one-entry injection register and all counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      inj_valid <= 1'b0;
      inj_data  <= '0;
      timestep  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      flt_cnt   <= '0;
      ifm_cnt   <= '0;
      res_cnt   <= '0;
      sticky    <= '0;
    end else begin
      if (inj_valid && inj_ready) begin
        inj_valid <= 1'b0;
      end
      if (flt_fire) begin
        inj_valid <= 1'b1;
        inj_data  <= flt_data;
      end else if (ifm_fire) begin
        inj_valid <= 1'b1;
        inj_data  <= ifm_stamped;
      end else if (res_fire) begin
        inj_valid <= 1'b1;
        inj_data  <= res_data;
      end

      case (state)
        IDLE: begin
          if (start) begin
            state    <= LOAD_FLT;
            busy     <= 1'b1;
            done     <= 1'b0;
            timestep <= '0;
            flt_cnt  <= '0;
            ifm_cnt  <= '0;
            res_cnt  <= '0;
            sticky   <= '0;
          end
        end
        LOAD_FLT: begin
          if (flt_fire) begin
            flt_cnt <= flt_cnt + FW'(1);
            if (flt_cnt == FLT_LAST) begin
              state <= RUN;
            end
          end
        end
        RUN: begin
          sticky <= sticky | pe_done;
          if (ifm_fire) begin
            ifm_cnt <= ifm_cnt + IW'(1);
          end
          if (res_fire) begin
            res_cnt <= res_cnt + RW'(1);
          end
          // Leave only once the last packet has left the output register.
          if ((ifm_cnt == IFM_MAX) && res_met && !inj_valid) begin
            state <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          sticky <= sticky | pe_done;
          if (&sticky) begin
            state <= (timestep == TS_LAST) ? FINISH : ADVANCE;
          end
        end
        ADVANCE: begin
          timestep <= timestep + TS_W'(1);
          ifm_cnt  <= '0;
          res_cnt  <= '0;
          sticky   <= '0;
          state    <= RUN;
        end
        FINISH: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_snn_inject_scheduler.sv
// Scoreboard bench for snn_inject_scheduler: directed source traffic, expected
// injections queued at issue time, a monitor pops and compares on each inject.
module tb_snn_inject_scheduler;

  localparam int PW = 33;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          flt_valid = 1'b0, ifm_valid = 1'b0, res_valid = 1'b0;
  logic          flt_ready, ifm_ready, res_ready;
  logic [PW-1:0] flt_data = '0, ifm_data = '0, res_data = '0;
  logic          inj_valid;
  logic          inj_ready = 1'b1;
  logic [PW-1:0] inj_data;
  logic [3:0]    pe_done = '0;
  logic [3:0]    timestep;
  logic          busy, done;

  int errors = 0;
  int checks = 0;
  int inj_cnt = 0;
  int base;

  logic [PW-1:0] flt_q[$], ifm_q[$], res_q[$], exp_q[$];
  logic          flt_fire = 1'b0, ifm_fire = 1'b0, res_fire = 1'b0;
  logic          pend = 1'b0;
  logic [PW-1:0] pend_data = '0;
  logic          cur_ts = 1'b0;
  logic [PW-1:0] d;

  snn_inject_scheduler #(
    .FILTER_WIDTH (8),
    .PKT_WIDTH    (PW),
    .NUM_PE       (4),
    .NUM_TS       (2),
    .FILTER_PKTS  (3),
    .IFMAP_PKTS   (5),
    .TS_W         (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .flt_valid (flt_valid),
    .flt_ready (flt_ready),
    .flt_data  (flt_data),
    .ifm_valid (ifm_valid),
    .ifm_ready (ifm_ready),
    .ifm_data  (ifm_data),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .inj_valid (inj_valid),
    .inj_ready (inj_ready),
    .inj_data  (inj_data),
    .pe_done   (pe_done),
    .timestep  (timestep),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [PW-1:0] stamp(input logic [PW-1:0] v, input logic ts);
    return {v[PW-1:1], ts};
  endfunction

  // Sampler/monitor: runs 1 time unit before each rising edge.
  initial begin
    forever begin
      @(negedge clk);
      #4;
      if (!rst_n) begin
        pend = 1'b0; flt_fire = 1'b0; ifm_fire = 1'b0; res_fire = 1'b0;
      end else begin
        if (pend) chk("inj_latency", 64'({inj_valid, inj_data}), 64'({1'b1, pend_data}));
        if (inj_valid && inj_ready) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL inj_unexpected: got 0x%0h expected no packet at %0t", inj_data, $time);
          end else begin
            chk("inj_order", 64'(inj_data), 64'(exp_q.pop_front()));
          end
          inj_cnt++;
        end
        flt_fire  = flt_valid && flt_ready;
        ifm_fire  = ifm_valid && ifm_ready;
        res_fire  = res_valid && res_ready;
        pend      = flt_fire || ifm_fire || res_fire;
        pend_data = flt_fire ? flt_data : (ifm_fire ? stamp(ifm_data, cur_ts) : res_data);
      end
    end
  end

  // Source drivers: hold front packet until accepted.
  initial begin
    forever begin
      @(negedge clk);
      if (flt_fire && flt_q.size() > 0) void'(flt_q.pop_front());
      flt_valid = flt_q.size() > 0;
      flt_data  = flt_valid ? flt_q[0] : '0;
    end
  end
  initial begin
    forever begin
      @(negedge clk);
      if (ifm_fire && ifm_q.size() > 0) void'(ifm_q.pop_front());
      ifm_valid = ifm_q.size() > 0;
      ifm_data  = ifm_valid ? ifm_q[0] : '0;
    end
  end
  initial begin
    forever begin
      @(negedge clk);
      if (res_fire && res_q.size() > 0) void'(res_q.pop_front());
      res_valid = res_q.size() > 0;
      res_data  = res_valid ? res_q[0] : '0;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset and idle: sources offering, no start.
    flt_q.push_back(33'h1_FFFF_0000);
    ifm_q.push_back(33'h0_EEEE_0001);
    res_q.push_back(33'h1_DDDD_0002);
    repeat (3) @(negedge clk);
    #4 chk("reset_inj_data", 64'(inj_data), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) begin
      @(negedge clk);
      #4 chk("idle_outputs", 64'({flt_ready, ifm_ready, res_ready, inj_valid, busy, done, timestep}), 64'h0);
    end
    flt_q.delete(); ifm_q.delete(); res_q.delete();
    repeat (2) @(negedge clk);

    // Filter load then timestep 0 ifmap.
    cur_ts = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      d = 33'h1_0000_0000 + 33'(k);
      flt_q.push_back(d); exp_q.push_back(d);
    end
    for (int k = 0; k < 5; k++) begin
      d = 33'h0_A000_0101 + 33'(k * 16);
      ifm_q.push_back(d); exp_q.push_back(stamp(d, 1'b0));
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #4 chk("start_state", 64'({busy, done, timestep}), 64'({1'b1, 1'b0, 4'h0}));
    for (int i = 0; i < 20 && flt_q.size() != 0; i++) @(negedge clk);
    chk("flt_loaded", 64'(flt_q.size()), 64'h0);
    pe_done = 4'b0001;
    flt_q.push_back(33'h1_0000_00FF);
    @(negedge clk);
    pe_done = 4'b0110;
    @(negedge clk);
    pe_done = 4'b0000;
    for (int i = 0; i < 40 && (exp_q.size() != 0 || ifm_q.size() != 0); i++) begin
      #4 chk("flt_ready_after_load", 64'(flt_ready), 64'h0);
      @(negedge clk);
    end
    chk("ts0_drained", 64'(exp_q.size()), 64'h0);
    repeat (4) begin
      @(negedge clk);
      #4 chk("ts0_wait_no_advance", 64'({timestep, busy, flt_ready, ifm_ready}), 64'({4'h0, 1'b1, 1'b0, 1'b0}));
    end

    // Timestep 1 traffic queued; last done pulse releases the advance.
    @(negedge clk);
    cur_ts = 1'b1;
    for (int k = 0; k < 5; k++) begin
      res_q.push_back(33'h1_C000_0010 + 33'(k));
      ifm_q.push_back(33'h0_B000_0100 + 33'(k * 16));
    end
    for (int k = 0; k < 4; k++) begin
      exp_q.push_back(stamp(33'h0_B000_0100 + 33'(k * 16), 1'b1));
      exp_q.push_back(33'h1_C000_0010 + 33'(k));
    end
    exp_q.push_back(stamp(33'h0_B000_0140, 1'b1));
    pe_done = 4'b1000;
    @(negedge clk);
    pe_done = 4'b0000;
    #4 chk("ts_before_advance", 64'(timestep), 64'h0);
    for (int i = 0; i < 10 && timestep != 4'h1; i++) @(negedge clk);
    chk("ts_advance", 64'(timestep), 64'h1);

    // Backpressure mid-run.
    base = inj_cnt;
    for (int i = 0; i < 40 && inj_cnt < base + 3; i++) @(negedge clk);
    chk("run_progress", 64'(inj_cnt >= base + 3), 64'h1);
    inj_ready = 1'b0;
    repeat (5) begin
      #4;
      chk("stall_hold", 64'({inj_valid, inj_data}), 64'({1'b1, exp_q[0]}));
      chk("stall_readies", 64'({flt_ready, ifm_ready, res_ready}), 64'h0);
      @(negedge clk);
    end
    inj_ready = 1'b1;
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(negedge clk);
    chk("ts1_drained", 64'(exp_q.size()), 64'h0);
    chk("ts1_injections", 64'(inj_cnt), 64'(base + 9));
    repeat (2) begin
      @(negedge clk);
      #4 chk("extra_res_stalled", 64'({res_ready, 4'(res_q.size())}), 64'({1'b0, 4'h1}));
    end

    // Final done pulses finish the inference.
    @(negedge clk);
    pe_done = 4'b1111;
    @(negedge clk);
    pe_done = 4'b0000;
    for (int i = 0; i < 10 && !done; i++) @(negedge clk);
    chk("inference_done", 64'({done, busy, timestep}), 64'({1'b1, 1'b0, 4'h1}));
    repeat (3) begin
      @(negedge clk);
      #4 chk("done_held", 64'({done, busy, flt_ready}), 64'({1'b1, 1'b0, 1'b0}));
    end
    flt_q.delete(); res_q.delete();
    repeat (2) @(negedge clk);

    // Second inference interrupted by an asynchronous reset.
    cur_ts = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      d = 33'h1_0000_0010 + 33'(k);
      flt_q.push_back(d); exp_q.push_back(d);
    end
    for (int k = 0; k < 5; k++) begin
      d = 33'h0_D000_0001 + 33'(k * 16);
      ifm_q.push_back(d); exp_q.push_back(stamp(d, 1'b0));
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #4 chk("restart_clears_done", 64'({done, busy, timestep}), 64'({1'b0, 1'b1, 4'h0}));
    base = inj_cnt;
    for (int i = 0; i < 40 && inj_cnt < base + 5; i++) @(negedge clk);
    #1 chk("pre_reset_inflight", 64'(inj_valid), 64'h1);
    #1 rst_n = 1'b0;
    #1;
    chk("async_reset", 64'({flt_ready, ifm_ready, res_ready, inj_valid, busy, done, timestep}), 64'h0);
    chk("async_reset_data", 64'(inj_data), 64'h0);
    flt_q.delete(); ifm_q.delete(); res_q.delete(); exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Fresh start after reset reloads filters at timestep 0.
    for (int k = 1; k <= 3; k++) begin
      d = 33'h1_0000_0020 + 33'(k);
      flt_q.push_back(d); exp_q.push_back(d);
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #4 chk("rerun_start", 64'({busy, done, timestep}), 64'({1'b1, 1'b0, 4'h0}));
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    chk("rerun_filters", 64'(exp_q.size()), 64'h0);
    #4 chk("rerun_ts", 64'({timestep, busy}), 64'({4'h0, 1'b1}));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/snn_inject_scheduler.md
Name: snn_inject_scheduler

Overview:
- Clocked controller that sequences all packet injection into the SNN PE mesh for one inference.
- Sequence: load filter packets once, then per timestep inject ifmap rows and the previous timestep's residue packets, then wait for all output PEs to report done before advancing the timestep.
- Sits between the filter/ifmap/residue sources and the single mesh injection port feeding Packet_in.

Parameters:
- FILTER_WIDTH, 8, bits per filter weight.
- PKT_WIDTH, 3*FILTER_WIDTH+9 (33), injection packet width.
- NUM_PE, 4, output PEs that must report done each timestep.
- NUM_TS, 2, timesteps per inference.
- FILTER_PKTS, 3, filter packets loaded before timestep 0.
- IFMAP_PKTS, 5, ifmap packets per timestep.
- TS_W, 4, timestep counter width.

Ports:
- clk, in, 1, clock.
- rst_n, in, 1, asynchronous active-low reset.
- start, in, 1, begin inference (sampled in IDLE only).
- flt_valid / flt_ready / flt_data, in/out/in, 1/1/PKT_WIDTH, filter source.
- ifm_valid / ifm_ready / ifm_data, in/out/in, 1/1/PKT_WIDTH, ifmap source.
- res_valid / res_ready / res_data, in/out/in, 1/1/PKT_WIDTH, residue feedback source.
- inj_valid / inj_ready / inj_data, out/in/out, 1/1/PKT_WIDTH, mesh injection port.
- pe_done, in, NUM_PE, per-PE single-cycle done pulses.
- timestep, out, TS_W, current timestep.
- busy, out, 1, inference in progress.
- done, out, 1, inference complete; held until next accepted start.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; all *_ready=0; inj_valid=0; inj_data=0; timestep=0; busy=0; done=0; all counters, sticky done vector and RR pointer cleared.
- Handshakes: a transfer occurs on a rising clk edge with valid&&ready. Sources must hold valid/data until accepted.
- Output register: one-entry. inj_data/inj_valid are registered, so accept-to-inj_valid latency is 1 cycle. Contents are held stable while inj_valid && !inj_ready.
- A source is ready only when granted, in a state that permits it, and (!inj_valid || inj_ready). This gives full throughput of 1 packet/cycle.
- IDLE: start=1 -> LOAD_FLT. Clears done, counters and sticky vector; sets busy=1.
- LOAD_FLT: only flt_ready may assert. After FILTER_PKTS acceptances -> RUN.
- RUN: arbitrates ifm vs res.
  - res is eligible only when timestep>0 and res_cnt<NUM_PE.
  - ifm is eligible while ifm_cnt<IFMAP_PKTS.
  - If both are valid and eligible, a 2-way round-robin grants them; the pointer flips after each grant. After reset/start the pointer favours ifm.
  - When required counts are met (ifm_cnt==IFMAP_PKTS, and res_cnt==NUM_PE if timestep>0, else 0) and inj_valid==0 -> WAIT_DONE.
- Ifmap stamping: inj_data[0] is replaced with timestep[0]. Filter and residue packets pass unmodified.
- Sticky done vector: ORs in pe_done during RUN and WAIT_DONE, so early done pulses are kept. pe_done in other states is ignored.
- WAIT_DONE: when the sticky vector is all ones:
  - timestep==NUM_TS-1 -> FINISH;
  - otherwise -> ADVANCE.
- ADVANCE (1 cycle): timestep+1; clears ifm_cnt, res_cnt and the sticky vector -> RUN.
- FINISH (1 cycle): done=1, busy=0 -> IDLE. timestep holds its final value until the next start clears it.
- start while busy: ignored.
- Extra source valids beyond the required counts: ready stays 0 (stall, no drop).
- rst_n asserted mid-transfer: immediate clear. An in-flight inj packet is discarded, and the mesh side is reset alongside.

Decomposition:
- Package snn_sched_pkg holds:
  - state enum {IDLE, LOAD_FLT, RUN, WAIT_DONE, ADVANCE, FINISH};
  - localparam TS_BIT=0;
  - pkt_width(FILTER_WIDTH) function.
- Sub-module rr_arb2: 2-request round-robin arbiter with registered last-grant pointer and an advance-on-accept input.

Test Plan:
- Reset/idle:
  - Stimulus: all sources valid, no start, 20 cycles.
  - Required: all readies 0, inj_valid 0, busy 0, done 0, timestep 0.
- Filter load:
  - Stimulus: start, flt offers 3 packets 0x1_0000_0001..3 back-to-back with inj_ready=1.
  - Required: inj_data appears 1 cycle after each accept; after the third, flt_ready=0 and the state is RUN.
- Arbitration:
  - Stimulus: timestep 1, ifm and res both continuously valid.
  - Required: grants alternate ifm,res,ifm,res,... until res_cnt=4; the remaining ifm packets then follow. Total 9 injections; ifmap packets carry bit0=1.
- Backpressure:
  - Stimulus: inj_ready=0 for 5 cycles mid-RUN.
  - Required: inj_data stable and all source readies 0 during the stall; no packet lost or duplicated (scoreboard count matches).
- Done/advance:
  - Stimulus: pe_done pulses 4'b0001 during RUN, then 4'b0110, then 4'b1000 in WAIT_DONE.
  - Required: ADVANCE occurs only after the last pulse; timestep 0->1. After timestep 1 completes, done=1 and busy=0.
- Async reset:
  - Stimulus: rst_n low mid-RUN, between clock edges.
  - Required: outputs clear immediately without a clk edge; a fresh start then reruns from LOAD_FLT with timestep 0.
